// File: rtl/galois_add_arbiter_if.sv
// galois_add_arbiter_if: requester and response bundle for the shared GF(p) adder
interface galois_add_arbiter_if #(
    parameter int N_BITS = 254,
    parameter int N_REQ = 4,
    parameter int ID_W = $clog2(N_REQ)
);
    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_ready;
    logic [N_REQ*N_BITS-1:0] req_a;
    logic [N_REQ*N_BITS-1:0] req_b;
    logic rsp_valid;
    logic rsp_ready;
    logic [N_BITS-1:0] rsp_sum;
    logic [ID_W-1:0] rsp_id;
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input req_ready, rsp_valid, rsp_sum, rsp_id
    );
    modport slave (
        input req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_id
    );
endinterface

// File: rtl/galois_add_arbiter.sv
// galois_add_arbiter: round-robin share of one registered GF(p) adder, one op in flight
module galois_add_arbiter #(
    parameter int N_BITS = 254,
    parameter logic [N_BITS-1:0] PRIME_MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter int N_REQ = 4,
    parameter int ID_W = $clog2(N_REQ)
) (
    input logic clk,
    input logic rst,
    galois_add_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;
    state_t state, state_n;
    logic [ID_W-1:0] last_grant, grant, idx, op_id, rsp_id_q;
    logic [N_BITS-1:0] op_a, op_b, rsp_sum_q, d;
    logic [N_BITS:0] t;
    logic rsp_valid_q, any_req, go;
    assign any_req = |bus.req_valid;
    assign go = state == IDLE && any_req && !rst;
    // Descending scan so the nearest requester above last_grant wins the final assignment
    always_comb begin
        grant = last_grant;
        idx = last_grant;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(last_grant) + k) % N_REQ);
            grant = bus.req_valid[idx] ? idx : grant;
        end
    end
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (any_req ? CALC : IDLE) : state == CALC ? OUT : (bus.rsp_ready ? IDLE : OUT);
    end
    assign t = {1'b0, op_a} + {1'b0, op_b};
    assign d = t[N_BITS-1:0] - PRIME_MODULUS;
    assign bus.req_ready = go ? N_REQ'(1) << grant : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum = rsp_sum_q;
    assign bus.rsp_id = rsp_id_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last_grant <= ID_W'(N_REQ - 1);
            op_a <= '0;
            op_b <= '0;
            op_id <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q <= '0;
            rsp_id_q <= '0;
        end else begin
            state <= state_n;
            if (go) begin
                op_a <= bus.req_a[int'(grant)*N_BITS +: N_BITS];
                op_b <= bus.req_b[int'(grant)*N_BITS +: N_BITS];
                op_id <= grant;
                last_grant <= grant;
            end
            if (state == CALC) begin
                rsp_sum_q <= t >= {1'b0, PRIME_MODULUS} ? d : t[N_BITS-1:0];
                rsp_id_q <= op_id;
                rsp_valid_q <= 1'b1;
            end
            if (state == OUT && bus.rsp_ready) rsp_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_galois_add_arbiter.sv
// tb_galois_add_arbiter: random and directed traffic against a queue-based arbitration model
module tb_galois_add_arbiter;
    localparam int N = 4;
    localparam int P = 251;
    typedef struct {int id; int sum;} exp_t;
    logic clk = 0, rst = 1, rr = 1;
    logic [N-1:0] va = '0, last_acc = '0;
    logic [N-1:0][7:0] aa = '0, bb = '0;
    int cnt [N];
    int n_pass = 0, n_chk = 0, cyc = 0, m_ptr = N - 1, m_gcyc = 0, g;
    bit m_idle = 1, prev_rst = 0, ev;
    logic [N-1:0] er;
    exp_t m_q [$];
    galois_add_arbiter_if #(.N_BITS(8), .N_REQ(N)) bus ();
    galois_add_arbiter #(.N_BITS(8), .PRIME_MODULUS(8'd251), .N_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    assign bus.req_valid = va;
    assign bus.req_a = aa;
    assign bus.req_b = bb;
    assign bus.rsp_ready = rr;
    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask
    function automatic int pick(logic [N-1:0] v);
        int i;
        for (int k = 1; k <= N; k++) begin
            i = (m_ptr + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction
    // Model: grant only when no op is outstanding; response due two cycles after its grant
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("ready_in_reset", int'(bus.req_ready), 0);
            m_idle = 1;
            m_ptr = N - 1;
            m_q.delete();
            prev_rst = 1;
        end else begin
            if (prev_rst) begin
                chk("reset_rsp_valid", int'(bus.rsp_valid), 0);
                chk("reset_rsp_sum", int'(bus.rsp_sum), 0);
                chk("reset_rsp_id", int'(bus.rsp_id), 0);
                prev_rst = 0;
            end
            g = m_idle ? pick(bus.req_valid) : -1;
            er = g >= 0 ? N'(1) << g : '0;
            ev = !m_idle && cyc >= m_gcyc + 2;
            chk("req_ready", int'(bus.req_ready), int'(er));
            chk("rsp_valid", int'(bus.rsp_valid), int'(ev));
            if (bus.rsp_valid && m_q.size() > 0) begin
                chk("rsp_sum", int'(bus.rsp_sum), m_q[0].sum);
                chk("rsp_id", int'(bus.rsp_id), m_q[0].id);
            end
            if (ev && rr) begin
                void'(m_q.pop_front());
                m_idle = 1;
            end
            if (g >= 0) begin
                m_q.push_back('{g, (int'(aa[g]) + int'(bb[g])) % P});
                m_idle = 0;
                m_gcyc = cyc;
                m_ptr = g;
            end
        end
    end
    task automatic put(int i, int a, int b, int c);
        aa[i] = 8'(a);
        bb[i] = 8'(b);
        cnt[i] = c;
        va[i] = 1'b1;
    endtask
    task automatic tick();
        @(negedge clk);
        last_acc = bus.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (last_acc[i]) begin
                cnt[i]--;
                if (cnt[i] > 0) begin
                    aa[i] = 8'($urandom_range(0, P - 1));
                    bb[i] = 8'($urandom_range(0, P - 1));
                end else va[i] = 1'b0;
            end
    endtask
    task automatic drain();
        int n = 0;
        while (!(va == '0 && m_idle && m_q.size() == 0 && !bus.rsp_valid) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("drain_timeout", n, 0);
    endtask
    initial begin
        int n;
        int ba [4] = '{250, 0, 125, 250};
        int bv [4] = '{1, 0, 125, 250};
        foreach (cnt[i]) cnt[i] = 0;
        repeat (2) tick();
        rst = 0;
        tick();
        put(2, 200, 100, 1);
        drain();
        for (int i = 0; i < 4; i++) begin
            put(0, ba[i], bv[i], 1);
            drain();
        end
        for (int i = 0; i < N; i++) put(i, $urandom_range(0, P - 1), $urandom_range(0, P - 1), 2);
        drain();
        put(2, $urandom_range(0, P - 1), $urandom_range(0, P - 1), 3);
        drain();
        rr = 0;
        put(1, 17, 240, 1);
        put(3, 250, 9, 1);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("bp_wait_timeout", n, 0);
        repeat (5) tick();
        rr = 1;
        drain();
        put(1, 10, 20, 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc[1] && n < 20);
        if (n >= 20) chk("grant1_timeout", n, 0);
        rst = 1;
        tick();
        rst = 0;
        tick();
        put(0, 33, 44, 1);
        put(1, 55, 66, 1);
        drain();
        put(3, 100, 200, 1);
        drain();
        put(0, 1, 2, 1);
        put(3, 3, 4, 1);
        drain();
        for (int c = 0; c < 400; c++) begin
            tick();
            for (int i = 0; i < N; i++)
                if (!va[i] && $urandom_range(0, 3) == 0)
                    put(i, $urandom_range(0, P - 1), $urandom_range(0, P - 1), $urandom_range(1, 3));
                else if (va[i] && $urandom_range(0, 19) == 0) begin
                    va[i] = 1'b0;
                    cnt[i] = 0;
                end
            rr = 1'($urandom_range(0, 1));
        end
        rr = 1;
        drain();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/galois_add_arbiter.md
# galois_add_arbiter

Round-robin arbiter that shares one modular adder over GF(p) among `N_REQ` requesters, such as MiMC round units or key-schedule logic. Each requester presents an operand pair with a valid/ready handshake. The arbiter grants one requester at a time and registers the modular sum. It returns the sum with the requester's index through a single valid/ready response port. Only one operation is in flight at any time.

## Interface
- `N_BITS`, 254, field element width.
- `PRIME_MODULUS`, 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001, field prime p, `N_BITS` wide.
- `N_REQ`, 4, number of requesters, ≥2.
- `ID_W`, `$clog2(N_REQ)`, width of the requester index.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  `N_REQ`  bit i set: requester i has an operand pair.
- `req_ready`  out  `N_REQ`  bit i set: requester i's pair is accepted this cycle.
- `req_a`  in  `N_REQ*N_BITS`  operand a; requester i occupies bits `[i*N_BITS +: N_BITS]`.
- `req_b`  in  `N_REQ*N_BITS`  operand b, packed the same way.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_sum`  out  `N_BITS`  (a+b) mod p.
- `rsp_id`  out  `ID_W`  index of the requester that owns `rsp_sum`.

## Operation
- FSM states: IDLE, CALC, OUT. Reset state is IDLE.
- **IDLE**
  - If any `req_valid` bit is set, grant g = the first set bit searching upward from `last_grant+1`, wrapping modulo `N_REQ`.
  - Drive `req_ready[g]=1` combinationally in the same cycle. All other ready bits stay 0.
  - Latch `req_a[g]`, `req_b[g]` and g into operand/id registers. Set `last_grant <= g`. Go to CALC.
  - If no `req_valid` bit is set, stay in IDLE.
- **CALC**
  - Compute t = a + b at width `N_BITS+1`, then d = t − p.
  - If d ≥ 0 (no borrow), register `rsp_sum <= d[N_BITS-1:0]`. Otherwise register `rsp_sum <= t[N_BITS-1:0]`.
  - Register `rsp_id <= latched id` and `rsp_valid <= 1`. Go to OUT.
- **OUT**
  - Hold `rsp_valid`, `rsp_sum` and `rsp_id` stable until the cycle where `rsp_valid && rsp_ready`.
  - In that cycle, clear `rsp_valid` on the next edge and go to IDLE.
- `req_ready` is all-zero in CALC and OUT regardless of `req_valid`.
- Operands must be < p. The arbiter does not check this. Out-of-range operands produce the truncated single-subtraction result defined above.
- Requesters hold `req_valid` and their operands until they see `req_ready`. The arbiter samples operands only in the grant cycle.
- If a requester drops `req_valid` before being granted, it is simply skipped.
- The pointer advances only on a grant. A lone requester is granted repeatedly, with no idle gap beyond the FSM cycles.

## Timing
- Reset values:
  - `rsp_valid=0`, `rsp_sum=0`, `rsp_id=0`, `req_ready=0`.
  - `last_grant=N_REQ-1`, so requester 0 has top priority after reset.
  - Operand registers reset to 0.
- Latency: grant at cycle T (IDLE, `req_ready` high). `rsp_valid` goes high at T+2, in the first OUT cycle.
- Throughput: with `rsp_ready` tied high, one operation every 3 cycles (IDLE→CALC→OUT→IDLE). The next grant comes at T+3.
- Backpressure: each cycle `rsp_ready` is low extends OUT by one cycle. No new grant is issued during OUT.
- Reset asserted in any state:
  - Next edge returns to IDLE with all reset values.
  - An in-flight result is discarded and never presented.
  - `req_ready` is 0 during any cycle with `rst` high.
- `rsp_ready` high while `rsp_valid` is low has no effect.

## Test plan
Tests use N_BITS=8, PRIME_MODULUS=251, N_REQ=4.
- **Single request, reduced sum:** only requester 2 is valid with a=200, b=100. Required: `req_ready[2]` in cycle T; `rsp_valid` at T+2 with `rsp_sum=49`, `rsp_id=2`; back in IDLE one cycle after the `rsp_ready` handshake.
- **Boundary sums:** (250,1)→0, (0,0)→0, (125,125)→250, (250,250)→249, each from requester 0.
- **Full contention:** all four `req_valid` held high, `rsp_ready` high. Required: grant order 0,1,2,3,0,1. Consecutive grants are exactly 3 cycles apart. Each `rsp_id` matches its grant.
- **Backpressure:** hold `rsp_ready` low for 5 cycles after `rsp_valid` rises, with requesters 1 and 3 pending. Required: `rsp_sum`/`rsp_id` stable throughout, `req_ready=0000`. After release, the next grant follows in IDLE, the cycle after the handshake.
- **Reset mid-operation:** assert `rst` for one cycle while in CALC after granting requester 1. Required: no response is produced and all outputs are 0 the next cycle. With requesters 0 and 1 valid, the first post-reset grant goes to 0.
- **Pointer wrap:** requester 3 is granted; then requesters 0 and 3 are both valid. Required: the next grant goes to 0.
